// File: rtl/pipe_adder_pkg.sv
// Shared constants and helpers for the pipelined adder.
package pipe_adder_pkg;

   localparam int DEFAULT_WIDTH  = 8;
   localparam int DEFAULT_STAGES = 2;

   // Number of result bits produced by each pipeline stage.
   function automatic int slice_width(input int width, input int stages);
      return width / stages;
   endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational N-bit ripple-carry chunk. Besides the carry out of the
// chunk it exposes the carry into its MSB so the last chunk of a word
// can derive signed overflow as cout ^ cmsb.
module adder_slice
   import pipe_adder_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] sum,
   output logic         cout,
   output logic         cmsb
);

   logic c;

   // Ripple the carry through the chunk bit by bit.
   always_comb begin
      c    = cin;
      cmsb = cin;
      sum  = '0;
      for (int i = 0; i < N; i++) begin
         cmsb   = c;
         sum[i] = a[i] ^ b[i] ^ c;
         c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      cout = c;
   end

endmodule

// File: rtl/pipe_adder.sv
// Pipelined add/subtract unit. The word is cut into STAGES slices of
// WIDTH/STAGES bits; slice k is added in stage k with the carry from
// slice k-1 taken from a register. Operand bits not yet consumed ride
// along in skew registers, and finished sum bits are concatenated as
// the beat moves forward, so all fields of a beat leave together.
//
// Handshake: a beat moves on an edge where valid && ready. The whole
// pipe advances together on en = !out_valid || out_ready, and in_ready
// is en (forced low during reset). While en is low every register,
// including the visible result, holds.
module pipe_adder
   import pipe_adder_pkg::*;
#(
   parameter int WIDTH  = DEFAULT_WIDTH,
   parameter int STAGES = DEFAULT_STAGES
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int N = slice_width(WIDTH, STAGES);

   logic             en;
   logic [WIDTH-1:0] b_eff;
   logic             c0;

   assign en       = !out_valid || out_ready;
   assign in_ready = en && rst_n;

   // Subtraction is a + ~b + 1: invert b and force the initial carry.
   assign b_eff = sub ? ~b : b;
   assign c0    = sub ? 1'b1 : cin;

   for (genvar k = 0; k < STAGES; k++) begin : g_st
      // Operand bits still to be consumed when the beat enters stage k.
      localparam int IW = WIDTH - k * N;

      logic [IW-1:0]        pa;
      logic [IW-1:0]        pb;
      logic                 pc;
      logic                 pv;
      logic [N-1:0]         s_sum;
      logic                 s_cout;
      logic                 s_cmsb;
      logic                 v;
      logic                 c;
      logic [(k+1)*N-1:0]   rs;
      logic [(k+1)*N-1:0]   ns;

      if (k == 0) begin : g_head
         assign pa = a;
         assign pb = b_eff;
         assign pc = c0;
         assign pv = in_valid;
         assign ns = s_sum;
      end else begin : g_tail
         assign pa = g_st[k-1].g_skew.ra;
         assign pb = g_st[k-1].g_skew.rb;
         assign pc = g_st[k-1].c;
         assign pv = g_st[k-1].v;
         assign ns = {s_sum, g_st[k-1].rs};
      end

      adder_slice #(.N(N)) u_slice (
         .a    (pa[N-1:0]),
         .b    (pb[N-1:0]),
         .cin  (pc),
         .sum  (s_sum),
         .cout (s_cout),
         .cmsb (s_cmsb)
      );

      // Stage valid, carry and partial sum; data only loads with a real beat
      // so bubbles never expose skew-register contents.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            v  <= 1'b0;
            c  <= 1'b0;
            rs <= '0;
         end else if (en) begin
            v <= pv;
            if (pv) begin
               c  <= s_cout;
               rs <= ns;
            end
         end
      end

      if (k < STAGES - 1) begin : g_skew
         logic [IW-N-1:0] ra;
         logic [IW-N-1:0] rb;

         // Skew registers: upper operand bits wait for their slice; no reset needed.
         always_ff @(posedge clk) begin
            if (en) begin
               ra <= pa[IW-1:N];
               rb <= pb[IW-1:N];
            end
         end
      end
   end

   // Signed overflow: carry into the MSB differs from carry out of it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ovf <= 1'b0;
      end else if (en && g_st[STAGES-1].pv) begin
         ovf <= g_st[STAGES-1].s_cout ^ g_st[STAGES-1].s_cmsb;
      end
   end

   assign out_valid = g_st[STAGES-1].v;
   assign sum       = g_st[STAGES-1].rs;
   assign cout      = g_st[STAGES-1].c;

endmodule

// File: tb/tb_pipe_adder.sv
// Bench for pipe_adder: directed cases on an 8-bit/2-stage instance plus
// randomized sweeps over several WIDTH/STAGES combinations, all checked
// through expected-result queues against an arithmetic reference model.
`timescale 1ns/1ps
module tb_pipe_adder;

   // ---------------- clock / counters ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference: plain integer arithmetic, result packed as {ovf, cout, sum}.
   function automatic logic [17:0] model(input int w, input longint ua, input longint ub,
                                         input bit ci, input bit sb);
      longint m, u, sa, sbv, r;
      logic [17:0] res;
      m   = longint'(1) << w;
      u   = sb ? (ua + m - ub) : (ua + ub + longint'(ci));
      sa  = (ua >= m / 2) ? ua - m : ua;
      sbv = (ub >= m / 2) ? ub - m : ub;
      r   = sb ? (sa - sbv) : (sa + sbv + longint'(ci));
      res = 18'(u % m);
      if (u >= m) res = res | (18'(1) << w);
      if (r >= m / 2 || r < -(m / 2)) res = res | (18'(1) << (w + 1));
      return res;
   endfunction

   task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- main 8-bit / 2-stage DUT ----------------
   localparam int MW = 8;
   localparam int MS = 2;

   logic          rst_n, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
   logic [MW-1:0] a, b, sum;
   logic [17:0]   m_res;
   logic [17:0]   exp_q[$];
   logic          rst_sw_n;
   wire  [8:0]    sweep_done;

   assign m_res = {8'b0, ovf, cout, sum};

   pipe_adder #(.WIDTH(MW), .STAGES(MS)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   // Driver: present one beat from a negedge, wait (bounded) for acceptance.
   task automatic send(input logic [7:0] va, input logic [7:0] vb, input logic vc, input logic vs);
      int t;
      a = va; b = vb; cin = vc; sub = vs; in_valid = 1'b1;
      t = 0;
      #1;
      while (!in_ready && t < 50) begin
         @(negedge clk); #1; t++;
      end
      if (!in_ready) begin
         n_checks++; n_fail++;
         $display("FAIL send_timeout: in_ready stayed 0, required 1");
      end else begin
         exp_q.push_back(model(MW, longint'(va), longint'(vb), vc, vs));
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Called right after send returns: out_valid must rise exactly MS cycles after accept.
   task automatic expect_latency(input string name);
      for (int i = 1; i < MS; i++) begin
         check({name, "_early"}, 18'(out_valid), 18'd0);
         @(negedge clk);
      end
      check(name, 18'(out_valid), 18'd1);
   endtask

   // Monitor: pop and compare on every output handshake; verify hold under stall.
   logic [17:0] held;
   bit          was_stalled = 1'b0;
   always @(negedge clk) begin
      #2;
      if (!rst_n) begin
         was_stalled = 1'b0;
      end else begin
         if (was_stalled) begin
            check("hold_data", m_res, held);
            check("hold_valid", 18'(out_valid), 18'd1);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected_beat: got 0x%0h, required no beat", m_res);
            end else begin
               check("result", m_res, exp_q.pop_front());
            end
         end
         was_stalled = out_valid && !out_ready;
         held        = m_res;
      end
   end

   // ---------------- main sequence ----------------
   initial begin
      int t;
      rst_n = 1'b0; rst_sw_n = 1'b0;
      in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_out_valid", 18'(out_valid), 18'd0);
      check("rst_result", m_res, 18'd0);
      check("rst_in_ready", 18'(in_ready), 18'd0);
      rst_n = 1'b1; rst_sw_n = 1'b1;
      @(negedge clk);

      // Wrap-around add
      send(8'hFF, 8'h01, 1'b0, 1'b0);
      expect_latency("lat_wrap");
      check("wrap_value", m_res, 18'h100);
      @(negedge clk);

      // Subtract with borrow, then signed overflow (cin must be ignored)
      send(8'h05, 8'h07, 1'b0, 1'b1);
      expect_latency("lat_sub");
      check("sub_borrow", m_res, 18'h0FE);
      @(negedge clk);
      send(8'h80, 8'h01, 1'b1, 1'b1);
      expect_latency("lat_sub_ovf");
      check("sub_ovf", m_res, 18'h37F);
      @(negedge clk);

      // Back-to-back beats, results on consecutive cycles
      send(8'h10, 8'h20, 1'b0, 1'b0);
      send(8'h7F, 8'h01, 1'b0, 1'b0);
      send(8'h01, 8'h01, 1'b0, 1'b0);
      check("b2b_second_valid", 18'(out_valid), 18'd1);
      check("b2b_second", m_res, 18'h280);
      @(negedge clk);
      check("b2b_third_valid", 18'(out_valid), 18'd1);
      check("b2b_third", m_res, 18'h002);
      @(negedge clk);
      check("b2b_drained", 18'(out_valid), 18'd0);

      // Backpressure with the pipe full
      out_ready = 1'b0;
      send(8'h11, 8'h22, 1'b0, 1'b0);
      send(8'h33, 8'h44, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         check("bp_in_ready", 18'(in_ready), 18'd0);
         check("bp_sum_held", m_res, 18'h033);
         @(negedge clk);
      end
      out_ready = 1'b1;
      repeat (4) @(negedge clk);
      #3;
      check("bp_all_out", 18'(exp_q.size()), 18'd0);
      @(negedge clk);

      // Reset with two beats in flight
      out_ready = 1'b0;
      send(8'hAA, 8'h01, 1'b0, 1'b0);
      send(8'h55, 8'h02, 1'b0, 1'b0);
      rst_n = 1'b0;
      exp_q.delete();
      out_ready = 1'b1;
      #1;
      check("rst_mid_in_ready", 18'(in_ready), 18'd0);
      @(negedge clk);
      check("rst_mid_flush", 18'(out_valid), 18'd0);
      check("rst_mid_result", m_res, 18'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("no_stale", 18'(out_valid), 18'd0);
      end
      send(8'h03, 8'h04, 1'b0, 1'b0);
      expect_latency("lat_after_rst");
      check("after_rst_value", m_res, 18'h007);
      @(negedge clk);

      // Randomized traffic with random backpressure on the main DUT
      for (int n = 0; n < 300; n++) begin
         out_ready = ($urandom_range(0, 3) != 0);
         in_valid  = ($urandom_range(0, 3) != 0);
         a   = 8'($urandom);
         b   = 8'($urandom);
         cin = 1'($urandom_range(0, 1));
         sub = 1'($urandom_range(0, 1));
         #1;
         if (in_valid && in_ready) exp_q.push_back(model(MW, longint'(a), longint'(b), cin, sub));
         @(negedge clk);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (MS + 3) @(negedge clk);
      #3;
      check("rand_drained", 18'(exp_q.size()), 18'd0);

      // Wait (bounded) for the parameter sweep to finish
      t = 0;
      while (sweep_done != 9'h1FF && t < 5000) begin
         @(negedge clk); t++;
      end
      if (sweep_done != 9'h1FF) begin
         n_checks++; n_fail++;
         $display("FAIL sweep_timeout: done=0x%0h, required 0x1ff", sweep_done);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // ---------------- randomized sweep over WIDTH x STAGES ----------------
   localparam int WL[3] = '{4, 8, 16};
   localparam int SL[3] = '{1, 2, 4};

   for (genvar wi = 0; wi < 3; wi++) begin : g_w
      for (genvar si = 0; si < 3; si++) begin : g_s
         localparam int W = WL[wi];
         localparam int S = SL[si];

         logic          iv, ir, ci, sb, ov, orr, co, of;
         logic [W-1:0]  ra, rb, rs;
         logic [17:0]   res;
         logic [17:0]   q[$];
         logic          done = 1'b0;

         assign res = 18'({of, co, rs});
         assign sweep_done[wi*3+si] = done;

         pipe_adder #(.WIDTH(W), .STAGES(S)) u_dut (
            .clk       (clk),
            .rst_n     (rst_sw_n),
            .in_valid  (iv),
            .in_ready  (ir),
            .a         (ra),
            .b         (rb),
            .cin       (ci),
            .sub       (sb),
            .out_valid (ov),
            .out_ready (orr),
            .sum       (rs),
            .cout      (co),
            .ovf       (of)
         );

         // Sweep driver: random beats and random out_ready.
         initial begin
            iv = 1'b0; ci = 1'b0; sb = 1'b0; orr = 1'b0; ra = '0; rb = '0;
            while (!rst_sw_n) @(negedge clk);
            @(negedge clk);
            for (int n = 0; n < 400; n++) begin
               orr = ($urandom_range(0, 3) != 0);
               iv  = ($urandom_range(0, 4) != 0);
               ra  = W'($urandom);
               rb  = W'($urandom);
               ci  = 1'($urandom_range(0, 1));
               sb  = 1'($urandom_range(0, 1));
               #1;
               if (iv && ir) q.push_back(model(W, longint'(ra), longint'(rb), ci, sb));
               @(negedge clk);
            end
            iv = 1'b0; orr = 1'b1;
            repeat (S + 3) @(negedge clk);
            #3;
            check($sformatf("sweep_w%0d_s%0d_drained", W, S), 18'(q.size()), 18'd0);
            done = 1'b1;
         end

         // Sweep monitor.
         always @(negedge clk) begin
            #2;
            if (rst_sw_n && ov && orr) begin
               if (q.size() == 0) begin
                  n_checks++; n_fail++;
                  $display("FAIL sweep_w%0d_s%0d_extra: got 0x%0h, required no beat", W, S, res);
               end else begin
                  check($sformatf("sweep_w%0d_s%0d", W, S), res, q.pop_front());
               end
            end
         end
      end
   end

endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 Parameter WIDTH, default 8: operand and sum width in bits; SHALL be at least 2.
REQ-002 Parameter STAGES, default 2: pipeline depth; SHALL divide WIDTH evenly, with 1 <= STAGES <= WIDTH.
REQ-003 Ports SHALL be exactly these:
- clk  input  1  rising-edge clock; one clock for the whole block
- rst_n  input  1  synchronous, active-low reset
- in_valid  input  1  operand beat present
- in_ready  output  1  block accepts the beat this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in, used in add mode only
- sub  input  1  0 = add, 1 = subtract
- out_valid  output  1  result beat present
- out_ready  input  1  consumer accepts the result
- sum  output  WIDTH  result
- cout  output  1  carry out of the MSB; in sub mode 1 = no borrow
- ovf  output  1  signed two's-complement overflow

Function
REQ-004 Add mode SHALL compute {cout,sum} = a + b + cin, modulo 2^(WIDTH+1).
REQ-005 Sub mode SHALL compute a + ~b + 1; cin is ignored.
REQ-006 ovf SHALL be 1 when both effective operand MSBs are equal and sum MSB differs from them (effective B = ~b in sub mode).
REQ-007 The datapath SHALL split into STAGES slices of WIDTH/STAGES bits.
- Slice k adds bits [(k+1)*W/S-1 : k*W/S] in stage k.
- The carry from slice k is registered and feeds slice k+1.
REQ-008 Operand bits not yet consumed SHALL be skew-delayed, and finished sum bits deskew-delayed, so all fields of one beat emerge together.
REQ-009 Latency SHALL be exactly STAGES cycles from an accepted beat (in_valid && in_ready at an edge) to out_valid with its result, absent stalls.
REQ-010 Each stage SHALL carry a valid bit; bubbles SHALL propagate without producing output beats.
REQ-011 Global advance en = !out_valid || out_ready; in_ready SHALL equal en combinationally.
REQ-012 When en = 0, all stage registers, valid bits and outputs SHALL hold; sum, cout and ovf SHALL stay stable while out_valid && !out_ready.
REQ-013 Accepted beats SHALL never be dropped, duplicated or reordered.
- Full throughput: one beat per cycle when out_ready is held at 1.
REQ-014 Simultaneous accept and output handoff in one cycle SHALL be legal and lose no data.
REQ-015 Wrap-around SHALL be silent modulo 2^WIDTH, with cout/ovf reported; no saturation.
REQ-016 With STAGES = 1 the block SHALL be a single registered adder with latency 1.

Reset
REQ-017 While rst_n = 0 at a clk edge, every stage valid bit and out_valid SHALL clear to 0, and sum, cout and ovf SHALL clear to 0.
REQ-018 While rst_n = 0, in_ready SHALL be 0.
REQ-019 Reset mid-operation SHALL discard every in-flight beat; none SHALL appear after reset release.
REQ-020 The first beat accepted after release SHALL emerge exactly STAGES cycles later.
REQ-021 Operand skew registers need no reset; nothing derived from them SHALL be visible while its valid bit is 0.

Structure
REQ-022 Shared package pipe_adder_pkg SHALL hold the default WIDTH/STAGES constants and a slice-width helper function (WIDTH/STAGES).
REQ-023 One sub-module, adder_slice, SHALL implement a combinational N-bit ripple chunk (a, b, cin -> sum, cout, MSB carry-in for ovf).
- pipe_adder instantiates one adder_slice per stage via generate.

Verification
REQ-024 WIDTH=8, STAGES=2, out_ready=1: a=0xFF, b=0x01, cin=0, sub=0 -> after 2 cycles sum=0x00, cout=1, ovf=0.
REQ-025 Sub mode: a=0x05, b=0x07 -> sum=0xFE, cout=0; a=0x80, b=0x01 -> sum=0x7F, ovf=1.
REQ-026 Back-to-back beats 0x10+0x20, then 0x7F+0x01, then 0x01+0x01 -> results 0x30, 0x80 (ovf=1), 0x02 on consecutive cycles.
REQ-027 Backpressure: out_ready=0 for 3 cycles with pipe full -> in_ready=0, sum held, and after release all beats come out in order with none lost.
REQ-028 rst_n=0 for one cycle with 2 beats in flight -> out_valid=0 the next cycle, no stale beat afterwards, and a fresh beat 0x03+0x04 -> 0x07 at latency 2.
REQ-029 Randomised sweep over WIDTH in {4,8,16} and STAGES in {1,2,4} against a reference model with random out_ready -> zero mismatches.
